lock_key_entry: RTL and testbench

LOCK_KEY_ENTRY -- requirements
Module: lock_key_entry

---
 rtl/lock_pkg.sv | 25 ++
 rtl/key_sync.sv | 25 ++
 rtl/lock_key_entry.sv | 141 ++++++++++++++
 tb/tb_lock_key_entry.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/lock_pkg.sv
// Shared definitions for the combination lock: key-entry FSM states,
// code length, digit range and the lock code itself.
package lock_pkg;

    localparam int unsigned CODE_LEN  = 6;
    localparam int unsigned MAX_DIGIT = 9;
    localparam int unsigned DIGIT_W   = 4;
    localparam int unsigned COUNT_W   = 3;

    // Lock code digits, most significant (first entered) first.
    localparam logic [DIGIT_W-1:0] LOCK_DIGIT_0 = 4'd0;
    localparam logic [DIGIT_W-1:0] LOCK_DIGIT_1 = 4'd1;
    localparam logic [DIGIT_W-1:0] LOCK_DIGIT_2 = 4'd7;
    localparam logic [DIGIT_W-1:0] LOCK_DIGIT_3 = 4'd0;
    localparam logic [DIGIT_W-1:0] LOCK_DIGIT_4 = 4'd2;
    localparam logic [DIGIT_W-1:0] LOCK_DIGIT_5 = 4'd8;

    typedef enum logic [1:0] {
        ST_IDLE        = 2'd0,
        ST_DEB_PRESS   = 2'd1,
        ST_HELD        = 2'd2,
        ST_DEB_RELEASE = 2'd3
    } key_state_e;

endpackage

// File: rtl/key_sync.sv
// Two-flop synchronizer for the raw active-low enter button; resets to
// the released level so a held button is not seen until after reset.
module key_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic key_n_i,
    output logic key_n_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
        end else begin
            meta_q <= key_n_i;
            sync_q <= meta_q;
        end
    end

    assign key_n_o = sync_q;

endmodule

// File: rtl/lock_key_entry.sv
// Debounces the enter button and turns each accepted press into a single
// digit (or error) strobe, counting valid digits toward a full code.
module lock_key_entry #(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
    parameter int unsigned CODE_LEN        = lock_pkg::CODE_LEN
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       key_n,
    input  logic [3:0] sw,
    input  logic       clear,
    output logic [3:0] digit,
    output logic       digit_valid,
    output logic       digit_err,
    output logic [2:0] entry_count,
    output logic       code_full
);

    import lock_pkg::*;

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic       key_sync_n;
    logic       pressed;

    key_state_e state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic       strobe_c;

    logic [3:0] digit_q, digit_d;
    logic       valid_q, valid_d;
    logic       err_q, err_d;
    logic [2:0] count_q, count_d;
    logic       full_q, full_d;

    key_sync u_key_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .key_n_i (key_n),
        .key_n_o (key_sync_n)
    );

    assign pressed = ~key_sync_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            digit_q <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            count_q <= '0;
            full_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            digit_q <= digit_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            count_q <= count_d;
            full_q  <= full_d;
        end
    end

    // Press FSM: the counter never exceeds DEBOUNCE_CYCLES, so it cannot wrap.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        strobe_c = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (pressed) begin
                    state_d = ST_DEB_PRESS;
                    cnt_d   = CNT_W'(1);
                end
            end
            ST_DEB_PRESS: begin
                if (!pressed) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_W'(DEBOUNCE_CYCLES)) begin
                    state_d  = ST_HELD;
                    cnt_d    = '0;
                    strobe_c = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_HELD: begin
                if (!pressed) begin
                    state_d = ST_DEB_RELEASE;
                    cnt_d   = CNT_W'(1);
                end
            end
            ST_DEB_RELEASE: begin
                if (pressed) begin
                    state_d = ST_HELD;
                    cnt_d   = '0;
                end else if (cnt_q >= CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Digit capture and entry count; clear wins over a pending increment.
    always_comb begin
        digit_d = digit_q;
        valid_d = 1'b0;
        err_d   = 1'b0;
        count_d = count_q;
        if (strobe_c) begin
            if (sw <= 4'(MAX_DIGIT)) begin
                digit_d = sw;
                valid_d = 1'b1;
            end else begin
                err_d = 1'b1;
            end
        end
        if (clear) begin
            count_d = '0;
        end else if (valid_q && (count_q != 3'(CODE_LEN))) begin
            count_d = count_q + 3'd1;
        end
        full_d = (count_d == 3'(CODE_LEN));
    end

    assign digit       = digit_q;
    assign digit_valid = valid_q;
    assign digit_err   = err_q;
    assign entry_count = count_q;
    assign code_full   = full_q;

endmodule

// File: tb/tb_lock_key_entry.sv
// Directed bench for lock_key_entry with a behavioural debounce/count model.
module tb_lock_key_entry;

    localparam int D    = 4;
    localparam int CLEN = 6;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       key_n = 1'b1;
    logic [3:0] sw = 4'd0;
    logic       clear = 1'b0;
    logic [3:0] digit;
    logic       digit_valid;
    logic       digit_err;
    logic [2:0] entry_count;
    logic       code_full;

    int tests = 0;
    int fails = 0;
    int n_dv  = 0;
    int n_err = 0;

    lock_key_entry #(.DEBOUNCE_CYCLES(D), .CODE_LEN(CLEN)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .key_n       (key_n),
        .sw          (sw),
        .clear       (clear),
        .digit       (digit),
        .digit_valid (digit_valid),
        .digit_err   (digit_err),
        .entry_count (entry_count),
        .code_full   (code_full)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a two-sample delay line, then run-length debounce. A press is
    // accepted after D+1 consecutive pressed samples; release after D.
    logic k1 = 1'b1, k2 = 1'b1, s;
    bit   latched = 0;
    int   run = 0;
    bit   m_dv = 0, m_err = 0, m_full = 0;
    int   m_digit = 0, m_count = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k1 = 1'b1; k2 = 1'b1; latched = 0; run = 0;
            m_dv = 0; m_err = 0; m_digit = 0; m_count = 0; m_full = 0;
        end else begin
            s  = ~k2;
            k2 = k1;
            k1 = key_n;
            if (clear) m_count = 0;
            else if (m_dv && m_count < CLEN) m_count = m_count + 1;
            m_full = (m_count == CLEN);
            m_dv = 0;
            m_err = 0;
            if (!latched) begin
                run = s ? run + 1 : 0;
                if (run == D + 1) begin
                    latched = 1;
                    run = 0;
                    if (sw <= 4'd9) begin
                        m_dv = 1;
                        m_digit = int'(sw);
                    end else begin
                        m_err = 1;
                    end
                end
            end else begin
                run = !s ? run + 1 : 0;
                if (run == D) begin
                    latched = 0;
                    run = 0;
                end
            end
        end
    end

    always @(posedge clk) begin
        #1;
        check("digit_valid", int'(digit_valid), int'(m_dv));
        check("digit_err", int'(digit_err), int'(m_err));
        check("digit", int'(digit), m_digit);
        check("entry_count", int'(entry_count), m_count);
        check("code_full", int'(code_full), int'(m_full));
        check("valid_err_exclusive", int'(digit_valid & digit_err), 0);
        if (digit_valid) n_dv++;
        if (digit_err) n_err++;
    end

    task automatic press(input logic [3:0] d, input int hold);
        @(negedge clk);
        sw = d;
        key_n = 1'b0;
        repeat (hold) @(negedge clk);
        key_n = 1'b1;
        repeat (10) @(negedge clk);
    endtask

    int base;
    int lv[7] = '{1, 0, 1, 0, 1, 0, 1};
    int ln[7] = '{2, 2, 3, 1, 2, 3, 4};
    logic [3:0] code[6] = '{4'd0, 4'd1, 4'd7, 4'd0, 4'd2, 4'd8};

    initial begin
        repeat (3) @(negedge clk);
        check("reset_digit", int'(digit), 0);
        check("reset_count", int'(entry_count), 0);
        check("reset_full", int'(code_full), 0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // Clean press: strobe on the 7th edge after key_n falls.
        @(negedge clk);
        sw = 4'd7;
        key_n = 1'b0;
        repeat (6) @(posedge clk);
        #1 check("clean_early", int'(digit_valid), 0);
        @(posedge clk);
        #1 check("clean_strobe", int'(digit_valid), 1);
        check("clean_digit", int'(digit), 7);
        repeat (13) @(negedge clk);
        key_n = 1'b1;
        repeat (10) @(negedge clk);
        check("clean_count", int'(entry_count), 1);

        // Invalid digit: error pulse only.
        base = n_err;
        press(4'hF, 12);
        check("inv_err_pulses", n_err - base, 1);
        check("inv_digit_held", int'(digit), 7);
        check("inv_count_held", int'(entry_count), 1);

        // Press bounce, then a stable hold.
        base = n_dv;
        @(negedge clk);
        sw = 4'd3;
        for (int i = 0; i < 3; i++) begin
            key_n = 1'b0;
            repeat (2) @(negedge clk);
            key_n = 1'b1;
            repeat (2) @(negedge clk);
        end
        check("bounce_no_strobe", n_dv - base, 0);
        key_n = 1'b0;
        repeat (12) @(negedge clk);
        key_n = 1'b1;
        repeat (10) @(negedge clk);
        check("bounce_one_strobe", n_dv - base, 1);
        check("bounce_digit", int'(digit), 3);

        // Release bounce, then re-press right when IDLE should be reached.
        base = n_dv;
        @(negedge clk);
        sw = 4'd4;
        key_n = 1'b0;
        repeat (12) @(negedge clk);
        for (int i = 0; i < 7; i++) begin
            key_n = 1'(lv[i]);
            repeat (ln[i]) @(negedge clk);
        end
        check("relbounce_one_strobe", n_dv - base, 1);
        key_n = 1'b0;
        repeat (6) @(posedge clk);
        #1 check("repress_early", int'(digit_valid), 0);
        @(posedge clk);
        #1 check("repress_strobe", int'(digit_valid), 1);
        repeat (5) @(negedge clk);
        key_n = 1'b1;
        repeat (10) @(negedge clk);
        check("relbounce_count", int'(entry_count), 4);

        // Clear, then a full code plus one extra digit.
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        check("clear_count", int'(entry_count), 0);
        base = n_dv;
        for (int i = 0; i < 6; i++) press(code[i], 10);
        check("full_pulses", n_dv - base, 6);
        check("full_count", int'(entry_count), 6);
        check("full_flag", int'(code_full), 1);
        press(4'd5, 10);
        check("sat_digit", int'(digit), 5);
        check("sat_count", int'(entry_count), 6);
        check("sat_pulses", n_dv - base, 7);

        // Clear in the same cycle as digit_valid.
        @(negedge clk);
        sw = 4'd2;
        key_n = 1'b0;
        repeat (7) @(negedge clk);
        check("clr_dv_high", int'(digit_valid), 1);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        check("clr_priority", int'(entry_count), 0);
        check("clr_full", int'(code_full), 0);
        key_n = 1'b1;
        repeat (10) @(negedge clk);

        // Reset mid-debounce with the button still held afterwards.
        base = n_dv;
        @(negedge clk);
        sw = 4'd6;
        key_n = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1 check("rst_dv", int'(digit_valid), 0);
        check("rst_err", int'(digit_err), 0);
        check("rst_digit", int'(digit), 0);
        check("rst_count", int'(entry_count), 0);
        check("rst_full", int'(code_full), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(posedge clk);
        #1 check("rst_aborted", n_dv - base, 0);
        @(posedge clk);
        #1 check("rst_full_debounce", int'(digit_valid), 1);
        check("rst_new_digit", int'(digit), 6);
        repeat (5) @(negedge clk);
        key_n = 1'b1;
        repeat (10) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
